fifo_pack2: RTL and testbench
=============================

Name: fifo_pack2

Overview:
- Downstream consumer of the read port of the req/ack FIFO.
- Accepts a stream of dw-bit words and packs consecutive pairs into one 2*dw-bit word.
- Presents each packed word on a req/ack output port to the next stage.
- A flush input forces out a half-filled word, so a stream with an odd number of words is never stranded.

Parameters:
- dw, 16: input word width; output data is 2*dw.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- d_in  in  dw  input word, from FIFO d_out.
- req_in  in  1  input word valid, from FIFO req_out.
- ack_in  out  1  block can take d_in this cycle, to FIFO ack_out.
- flush  in  1  emit pending half word.
- d_out  out  2*dw  packed word; first-received word in [dw-1:0], second in [2dw-1:dw].
- req_out  out  1  d_out valid.
- ack_out  in  1  downstream accepts d_out.
- half_out  out  1  d_out carries only the low half; upper half is zero.

Behaviour:
- Handshake: a transfer happens on a rising edge where req and ack are both 1. Each side of the block is one handshake pair.
- req_out, d_out and half_out are registered.
- ack_in is combinational: ack_in = ~rst & (state!=FULL | ack_out).
- Reset (rst=1 at an edge): state=EMPTY, req_out=0, d_out=0, half_out=0, low-half register=0. Reset mid-transfer discards held data; ack_in is 0 while rst=1.
- States:
  - EMPTY: nothing held. Input transfer stores d_in in low half -> HALF.
  - HALF: low half held. Input transfer loads d_out={d_in,low}, half_out=0, req_out=1 -> FULL. Otherwise, if flush=1: d_out={0,low}, half_out=1, req_out=1 -> FULL.
  - FULL: req_out=1, word held stable until ack_out.
    - Output transfer with no input transfer -> EMPTY, req_out=0.
    - Output transfer with an input transfer in the same cycle -> low=d_in, HALF, req_out=0.
    - Without an output transfer, d_out, half_out and req_out stay unchanged, and ack_in=0.
- Flush rules:
  - Flush is honoured only in HALF.
  - In EMPTY and FULL it is ignored and does not persist. The requester holds flush until half_out is seen, or until state is EMPTY.
- Simultaneous input and flush in HALF: the pair completes, half_out=0, and the flush is consumed.
- Latency and throughput:
  - The second word of a pair appears on d_out one cycle after its transfer.
  - Sustained throughput is one input word per cycle when ack_out is held at 1: one packed word every 2 cycles.
- Data integrity: no word is dropped or duplicated, and input order is preserved across flushes.
- Values of d_in while req_in=0 are ignored.

Optional Feature:
- Macro: FIFO_PACK2_PARITY_EN.
- Defined: extra output port par_out (1 bit, registered), equal to the even-parity XOR of all 2*dw bits of d_out. It updates in the same cycle as d_out and resets to 0.
- Undefined: the port par_out does not exist, and there is no parity logic.

Decomposition:
- Shared package: state encoding constants EMPTY=2'd0, HALF=2'd1, FULL=2'd2, plus default dw=16.
- No sub-module; a single flat module, since the datapath is one holding register plus the output register.

Test Plan:
- Reset then input words 16'h1111 and 16'h2222 back-to-back, ack_out=1 -> d_out=32'h2222_1111, half_out=0, req_out=1 for exactly one cycle.
- Input 16'hABCD then flush=1, ack_out=1 -> d_out=32'h0000_ABCD, half_out=1; state returns to EMPTY.
- Hold ack_out=0 with the output FULL and req_in=1 -> ack_in=0, and d_out stable for 10 cycles; release ack_out -> the next input is accepted in that same cycle.
- Hold ack_out=1 and req_in=1 continuously with incrementing d_in 0..99 -> 50 outputs {2k+1, 2k}, with no gaps beyond one per pair.
- Assert rst for 1 cycle while in HALF with 16'h5555 held, then input 16'h0001 and 16'h0002 -> d_out=32'h0002_0001; 16'h5555 never appears.
- Randomized req_in, ack_out and flush against a scoreboard model, in the style of the FIFO bench -> all outputs match, with at least 50 words, 5 flushes and 5 backpressure events.

Source files
------------

// File: rtl/fifo_pack2_pkg.sv
// Shared definitions for the word-pair packer: state encoding and default width.
package fifo_pack2_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        HALF  = 2'd1,   // low half held, waiting for partner word or flush
        FULL  = 2'd2    // packed word presented on the output port
    } state_t;

endpackage : fifo_pack2_pkg

// File: rtl/fifo_pack2.sv
// fifo_pack2: packs consecutive pairs of dw-bit words from a req/ack source
// into one 2*dw-bit word on a req/ack output. First word lands in the low half.
// A flush in HALF pushes out a lone word with half_out=1 and a zero upper half.
// Optional build macro FIFO_PACK2_PARITY_EN adds a registered even-parity
// output par_out covering all bits of d_out.
module fifo_pack2
    import fifo_pack2_pkg::*;
#(
    parameter int dw = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [dw-1:0]   d_in,
    input  logic            req_in,
    output logic            ack_in,
    input  logic            flush,
    output logic [2*dw-1:0] d_out,
    output logic            req_out,
    input  logic            ack_out,
    output logic            half_out
`ifdef FIFO_PACK2_PARITY_EN
    ,
    output logic            par_out
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [dw-1:0]     r_low;
    logic [dw-1:0]     w_low_nxt;
    logic [2*dw-1:0]   r_d_out;
    logic [2*dw-1:0]   w_d_out_nxt;
    logic              r_req_out;
    logic              w_req_out_nxt;
    logic              r_half_out;
    logic              w_half_out_nxt;
    logic              w_ack_in;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Input is accepted unless a packed word is stuck waiting downstream.
    assign w_ack_in   = ~rst & ((r_state != FULL) | ack_out);
    assign w_in_xfer  = req_in & w_ack_in;
    assign w_out_xfer = r_req_out & ack_out;

    // Next-state and next-output decode for the pairing FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        w_state_nxt    = r_state;
        w_low_nxt      = r_low;
        w_d_out_nxt    = r_d_out;
        w_req_out_nxt  = r_req_out;
        w_half_out_nxt = r_half_out;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_low_nxt   = d_in;
                    w_state_nxt = HALF;
                end
            end
            HALF: begin
                // A completing pair takes priority and swallows a coincident flush.
                if (w_in_xfer) begin
                    w_d_out_nxt    = {d_in, r_low};
                    w_half_out_nxt = 1'b0;
                    w_req_out_nxt  = 1'b1;
                    w_state_nxt    = FULL;
                end else if (flush) begin
                    w_d_out_nxt    = {{dw{1'b0}}, r_low};
                    w_half_out_nxt = 1'b1;
                    w_req_out_nxt  = 1'b1;
                    w_state_nxt    = FULL;
                end
            end
            FULL: begin
                // Word held stable until downstream takes it; a new word may
                // enter in the same cycle the old one leaves.
                if (w_out_xfer) begin
                    w_req_out_nxt = 1'b0;
                    if (w_in_xfer) begin
                        w_low_nxt   = d_in;
                        w_state_nxt = HALF;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt   = EMPTY;
                w_req_out_nxt = 1'b0;
            end
        endcase
    end

    // State, holding register and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            // NOTE: the low-half holding register is reset too, so a discarded word can never leak out later.
            r_state    <= EMPTY;
            r_low      <= '0;
            r_d_out    <= '0;
            r_req_out  <= 1'b0;
            r_half_out <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_low      <= w_low_nxt;
            r_d_out    <= w_d_out_nxt;
            r_req_out  <= w_req_out_nxt;
            r_half_out <= w_half_out_nxt;
        end
    end

`ifdef FIFO_PACK2_PARITY_EN
    logic r_par;

    // Parity tracks the word being loaded so it changes in step with d_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ^w_d_out_nxt;
        end
    end

    assign par_out = r_par;
`endif

    assign ack_in   = w_ack_in;
    assign d_out    = r_d_out;
    assign req_out  = r_req_out;
    assign half_out = r_half_out;

endmodule : fifo_pack2

// File: tb/tb_fifo_pack2.sv
// Bench for fifo_pack2: directed vectors with literal expectations, plus a
// queue-based reference model compared against the outputs every cycle.
module tb_fifo_pack2;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   d_in;
    logic            req_in;
    logic            ack_in;
    logic            flush;
    logic [2*DW-1:0] d_out;
    logic            req_out;
    logic            ack_out;
    logic            half_out;
`ifdef FIFO_PACK2_PARITY_EN
    logic            par_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_pack2 #(.dw(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .req_in   (req_in),
        .ack_in   (ack_in),
        .flush    (flush),
        .d_out    (d_out),
        .req_out  (req_out),
        .ack_out  (ack_out),
        .half_out (half_out)
`ifdef FIFO_PACK2_PARITY_EN
        ,
        .par_out  (par_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words accepted but not yet paired, plus one slot for the word offered downstream.
    logic [DW-1:0]   pend_q[$];
    logic            m_out_valid = 1'b0;
    logic [2*DW-1:0] m_out_word  = '0;
    logic            m_out_half  = 1'b0;

    always @(posedge clk) begin : model
        bit in_x;
        bit was_lone;
        if (rst) begin
            m_out_valid = 1'b0;
            pend_q.delete();
        end else begin
            in_x     = req_in && (!m_out_valid || ack_out);
            was_lone = !m_out_valid && (pend_q.size() == 1);
            if (m_out_valid && ack_out) m_out_valid = 1'b0;
            if (in_x) pend_q.push_back(d_in);
            if (pend_q.size() == 2) begin
                m_out_word  = {pend_q[1], pend_q[0]};
                m_out_half  = 1'b0;
                m_out_valid = 1'b1;
                pend_q.delete();
            end else if (was_lone && flush && !in_x) begin
                m_out_word  = {{DW{1'b0}}, pend_q[0]};
                m_out_half  = 1'b1;
                m_out_valid = 1'b1;
                pend_q.delete();
            end
        end
    end

    // Compare on the falling edge: outputs settled, next-edge inputs applied.
    always @(negedge clk) begin
        check("ack_in", ack_in, !rst && !(m_out_valid && !ack_out));
        check("req_out", req_out, m_out_valid);
        if (m_out_valid) begin
            check("d_out", d_out, m_out_word);
            check("half_out", half_out, m_out_half);
`ifdef FIFO_PACK2_PARITY_EN
            check("par_out", par_out, ^m_out_word);
`endif
        end
    end

    // ---------------- transfer monitor ----------------
    logic [2*DW-1:0] log_q[$];
    int in_cnt = 0;
    int n_flush = 0;
    int n_bp = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (req_out && ack_out) begin
                log_q.push_back(d_out);
                if (half_out) n_flush++;
            end
            if (req_in && ack_in) in_cnt++;
            if (req_out && !ack_out) n_bp++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic [DW-1:0] d, input logic f, input logic a);
        req_in  = r;
        d_in    = d;
        flush   = f;
        ack_out = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic r, input logic [DW-1:0] d, input logic f, input logic a);
        drive(r, d, f, a);
        tick();
    endtask

    initial begin
        int mark;
        int cnt0;
        int hits;
        logic [2*DW-1:0] w;

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) tick();
        check("reset_req_out", req_out, 0);
        check("reset_d_out", d_out, 0);
        check("reset_half_out", half_out, 0);
        check("reset_ack_in", ack_in, 0);
        rst = 1'b0;
        tick();

        // Back-to-back pair with downstream ready.
        cyc(1'b1, 16'h1111, 1'b0, 1'b1);
        cyc(1'b1, 16'h2222, 1'b0, 1'b1);
        check("pair_d_out", d_out, 32'h2222_1111);
        check("pair_half", half_out, 0);
        check("pair_req_on", req_out, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("pair_req_off", req_out, 0);

        // Lone word forced out by flush.
        cyc(1'b1, 16'hABCD, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        check("flush_d_out", d_out, 32'h0000_ABCD);
        check("flush_half", half_out, 1);
        check("flush_req", req_out, 1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        check("flush_drained", req_out, 0);
        // Flush held in EMPTY must not create a word.
        cyc(1'b0, '0, 1'b1, 1'b1);
        check("flush_empty_ignored", req_out, 0);

        // Backpressure: output held, input refused for 10 cycles.
        cyc(1'b1, 16'h0003, 1'b0, 1'b0);
        cyc(1'b1, 16'h0004, 1'b0, 1'b0);
        drive(1'b1, 16'h0005, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_ack_in", ack_in, 0);
            tick();
            check("bp_d_out", d_out, 32'h0004_0003);
            check("bp_req", req_out, 1);
        end
        drive(1'b1, 16'h0005, 1'b0, 1'b1);
        #1;
        check("bp_release_ack", ack_in, 1);
        tick();
        check("bp_release_req", req_out, 0);
        cyc(1'b1, 16'h0006, 1'b0, 1'b1);
        check("bp_next_pair", d_out, 32'h0006_0005);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Sustained streaming of 0..99 with downstream always ready.
        mark = log_q.size();
        cnt0 = in_cnt;
        for (int k = 0; k < 100; k++) cyc(1'b1, DW'(k), 1'b0, 1'b1);
        check("stream_inputs_100cyc", in_cnt - cnt0, 100);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("stream_outputs", log_q.size() - mark, 50);
        for (int k = 0; k < 50; k++) begin
            w = {DW'(2 * k + 1), DW'(2 * k)};
            if (mark + k < log_q.size()) check("stream_word", log_q[mark + k], w);
        end

        // Reset while holding a lone word discards it.
        cyc(1'b1, 16'h5555, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        mark = log_q.size();
        cyc(1'b1, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 16'h0002, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("rst_outputs", log_q.size() - mark, 1);
        if (log_q.size() > mark) check("rst_word", log_q[mark], 32'h0002_0001);
        hits = 0;
        for (int i = mark; i < log_q.size(); i++)
            if (log_q[i][15:0] == 16'h5555 || log_q[i][31:16] == 16'h5555) hits++;
        check("rst_no_stale", hits, 0);

        // Random traffic against the model.
        cnt0 = in_cnt;
        n_flush = 0;
        n_bp = 0;
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) < 3);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);
        check("rand_words_ge50", (in_cnt - cnt0) >= 50, 1);
        check("rand_flush_ge5", n_flush >= 5, 1);
        check("rand_bp_ge5", n_bp >= 5, 1);
        check("rand_drained", req_out, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_pack2
